// File: rtl/contador_m_prog_if.sv
// Control/status bundle between the timing FSM, the programmable-modulus
// counter and the PWM comparators. Clock and reset are plain ports on the counter.
interface contador_m_prog_if #(
    parameter int N = 10
);
    logic         zera_s;
    logic         conta;
    logic         dir;
    logic         modo_sat;
    logic         carrega_lim;
    logic [N-1:0] lim_in;
    logic         carrega;
    logic [N-1:0] dado;
    logic [N-1:0] limiar;

    logic [N-1:0] Q;
    logic [N-1:0] lim;
    logic         fim;
    logic         inicio;
    logic         meio;
    logic         acima;
    logic         tick;
    logic         saturou;

    // Timing FSM side: drives the controls, observes the count and flags.
    modport master (
        output zera_s, conta, dir, modo_sat, carrega_lim, lim_in,
               carrega, dado, limiar,
        input  Q, lim, fim, inicio, meio, acima, tick, saturou
    );

    // Counter side.
    modport slave (
        input  zera_s, conta, dir, modo_sat, carrega_lim, lim_in,
               carrega, dado, limiar,
        output Q, lim, fim, inicio, meio, acima, tick, saturou
    );
endinterface

// File: rtl/contador_m_prog.sv
// Programmable-modulus up/down counter with wrap/saturate modes, parallel
// load, threshold compare and a cascade tick for chaining timebases.
module contador_m_prog #(
    parameter int N         = 10,
    parameter int M_DEFAULT = 500
) (
    input  logic              clock,
    input  logic              reset_n,
    contador_m_prog_if.slave  bus
);

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_CLEAR,
        ACT_LOAD_LIM,
        ACT_LOAD,
        ACT_COUNT,
        ACT_HOLD
    } action_t;

    localparam logic [N-1:0] LIM_RST = N'(M_DEFAULT - 1);
    localparam logic [N-1:0] ONE     = N'(1);
    localparam logic [N:0]   ONE_EXT = (N+1)'(1);

    logic [N-1:0] q_r, q_nxt;
    logic [N-1:0] lim_r, lim_nxt;
    logic         sat_r, sat_nxt;

    action_t      action;
    logic         at_top;
    logic         at_bot;
    logic         at_bound;
    logic [N:0]   half_m1;

    // Exactly one action per edge, chosen by fixed priority.
    always_comb begin
        if (!reset_n)              action = ACT_RESET;
        else if (bus.zera_s)       action = ACT_CLEAR;
        else if (bus.carrega_lim)  action = ACT_LOAD_LIM;
        else if (bus.carrega)      action = ACT_LOAD;
        else if (bus.conta)        action = ACT_COUNT;
        else                       action = ACT_HOLD;
    end

    assign at_top   = (q_r == lim_r);
    assign at_bot   = (q_r == '0);
    assign at_bound = bus.dir ? at_bot : at_top;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        q_nxt   = q_r;
        lim_nxt = lim_r;
        sat_nxt = sat_r;
        unique case (action)
            ACT_RESET: begin
                q_nxt   = '0;
                lim_nxt = LIM_RST;
                sat_nxt = 1'b0;
            end
            ACT_CLEAR: begin
                q_nxt   = '0;
                sat_nxt = 1'b0;
            end
            ACT_LOAD_LIM: begin
                lim_nxt = bus.lim_in;
                q_nxt   = '0;
                sat_nxt = 1'b0;
            end
            ACT_LOAD: begin
                // Clamp keeps Q inside the current modulus.
                q_nxt   = (bus.dado <= lim_r) ? bus.dado : lim_r;
                sat_nxt = 1'b0;
            end
            ACT_COUNT: begin
                if (at_bound) begin
                    if (bus.modo_sat) sat_nxt = 1'b1;
                    else              q_nxt   = bus.dir ? lim_r : '0;
                end else begin
                    q_nxt = bus.dir ? (q_r - ONE) : (q_r + ONE);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock) begin
        q_r   <= q_nxt;
        lim_r <= lim_nxt;
        sat_r <= sat_nxt;
    end

    // Midpoint floor(M/2)-1 in N+1 bits so M = 2^N does not overflow.
    assign half_m1 = (({1'b0, lim_r} + ONE_EXT) >> 1) - ONE_EXT;

    assign bus.Q       = q_r;
    assign bus.lim     = lim_r;
    assign bus.saturou = sat_r;
    assign bus.fim     = at_top;
    assign bus.inicio  = at_bot;
    assign bus.meio    = (lim_r != '0) && ({1'b0, q_r} == half_m1);
    assign bus.acima   = (q_r >= bus.limiar);
    assign bus.tick    = (action == ACT_COUNT) && !bus.modo_sat && at_bound;

endmodule

// File: tb/tb_contador_m_prog.sv
// Directed bench for contador_m_prog: wrap/saturate counting, priorities,
// clamping, compare flags, M = 1 and mid-count reset.
module tb_contador_m_prog;

    localparam int N = 10;

    logic clock = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    contador_m_prog_if #(.N(N)) bus ();

    contador_m_prog #(.N(N), .M_DEFAULT(500)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    int exp_dn [12] = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3};
    int exp_sq [5]  = '{8, 9, 9, 9, 9};
    int exp_ss [5]  = '{0, 0, 1, 1, 1};
    int exp_ac [3]  = '{0, 1, 1};

    initial begin
        int prev;
        int eq;

        reset_n         = 1'b0;
        bus.zera_s      = 1'b0;
        bus.conta       = 1'b0;
        bus.dir         = 1'b0;
        bus.modo_sat    = 1'b0;
        bus.carrega_lim = 1'b0;
        bus.lim_in      = '0;
        bus.carrega     = 1'b0;
        bus.dado        = '0;
        bus.limiar      = '0;
        repeat (2) step();
        reset_n = 1'b1;
        #1;
        check("rst_q",      32'(bus.Q), 0);
        check("rst_lim",    32'(bus.lim), 499);
        check("rst_sat",    32'(bus.saturou), 0);
        check("rst_fim",    32'(bus.fim), 0);
        check("rst_inicio", 32'(bus.inicio), 1);
        check("rst_meio",   32'(bus.meio), 0);
        check("rst_tick",   32'(bus.tick), 0);

        // Default modulus 500, two full wraps.
        bus.conta = 1'b1;
        #1;
        for (int c = 0; c < 1000; c++) begin
            eq = c % 500;
            check("run_q",    32'(bus.Q), 32'(eq));
            check("run_fim",  32'(bus.fim), 32'(eq == 499));
            check("run_meio", 32'(bus.meio), 32'(eq == 249));
            check("run_tick", 32'(bus.tick), 32'(eq == 499));
            step();
        end
        check("run_end_q", 32'(bus.Q), 0);

        // M = 5, counting down with wrap.
        bus.conta       = 1'b0;
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd4;
        step();
        bus.carrega_lim = 1'b0;
        check("m5_lim", 32'(bus.lim), 4);
        check("m5_q",   32'(bus.Q), 0);
        bus.dir   = 1'b1;
        bus.conta = 1'b1;
        prev      = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("dn_tick", 32'(bus.tick), 32'(prev == 0));
            step();
            check("dn_q",    32'(bus.Q), 32'(exp_dn[k]));
            check("dn_meio", 32'(bus.meio), 32'(exp_dn[k] == 1));
            prev = exp_dn[k];
        end

        // Saturate at the top with M = 10.
        bus.conta       = 1'b0;
        bus.dir         = 1'b0;
        bus.modo_sat    = 1'b1;
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd9;
        step();
        bus.carrega_lim = 1'b0;
        bus.carrega     = 1'b1;
        bus.dado        = 10'd7;
        step();
        bus.carrega = 1'b0;
        check("sat_load_q", 32'(bus.Q), 7);
        bus.conta = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("sat_tick", 32'(bus.tick), 0);
            step();
            check("sat_q",   32'(bus.Q), 32'(exp_sq[k]));
            check("sat_flg", 32'(bus.saturou), 32'(exp_ss[k]));
        end
        bus.conta  = 1'b0;
        bus.zera_s = 1'b1;
        step();
        bus.zera_s = 1'b0;
        check("zera_q",   32'(bus.Q), 0);
        check("zera_sat", 32'(bus.saturou), 0);
        check("zera_lim", 32'(bus.lim), 9);

        // Priority between simultaneous controls, then load clamping.
        bus.modo_sat = 1'b0;
        bus.carrega  = 1'b1;
        bus.dado     = 10'd5;
        step();
        check("pri_pre_q", 32'(bus.Q), 5);
        bus.zera_s      = 1'b1;
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd20;
        bus.dado        = 10'd3;
        bus.conta       = 1'b1;
        #1;
        check("pri_tick", 32'(bus.tick), 0);
        step();
        check("pri_zera_q",   32'(bus.Q), 0);
        check("pri_zera_lim", 32'(bus.lim), 9);
        bus.zera_s = 1'b0;
        step();
        check("pri_lim_lim", 32'(bus.lim), 20);
        check("pri_lim_q",   32'(bus.Q), 0);
        bus.carrega_lim = 1'b0;
        bus.dado        = 10'd30;
        step();
        check("clamp_q", 32'(bus.Q), 20);
        bus.carrega = 1'b0;
        bus.conta   = 1'b0;

        // Threshold compare around limiar = 100.
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd199;
        step();
        bus.carrega_lim = 1'b0;
        bus.carrega     = 1'b1;
        bus.dado        = 10'd98;
        bus.limiar      = 10'd100;
        step();
        bus.carrega = 1'b0;
        check("ac_q98",  32'(bus.Q), 98);
        check("ac_98",   32'(bus.acima), 0);
        bus.conta = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ac_q",  32'(bus.Q), 32'(99 + k));
            check("ac_fl", 32'(bus.acima), 32'(exp_ac[k]));
        end

        // M = 1.
        bus.conta       = 1'b0;
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd0;
        step();
        bus.carrega_lim = 1'b0;
        check("m1_lim",    32'(bus.lim), 0);
        check("m1_fim",    32'(bus.fim), 1);
        check("m1_inicio", 32'(bus.inicio), 1);
        check("m1_meio",   32'(bus.meio), 0);
        check("m1_tick0",  32'(bus.tick), 0);
        bus.conta = 1'b1;
        #1;
        check("m1_tick1", 32'(bus.tick), 1);
        step();
        check("m1_q",     32'(bus.Q), 0);
        check("m1_sat0",  32'(bus.saturou), 0);
        bus.modo_sat = 1'b1;
        #1;
        check("m1_tick_sat", 32'(bus.tick), 0);
        step();
        check("m1_sat1", 32'(bus.saturou), 1);
        check("m1_q2",   32'(bus.Q), 0);

        // Reset in the middle of a count with saturou set.
        bus.conta       = 1'b0;
        bus.carrega_lim = 1'b1;
        bus.lim_in      = 10'd299;
        step();
        bus.carrega_lim = 1'b0;
        bus.dir         = 1'b1;
        bus.conta       = 1'b1;
        step();
        bus.dir = 1'b0;
        repeat (123) step();
        check("mid_q",   32'(bus.Q), 123);
        check("mid_lim", 32'(bus.lim), 299);
        check("mid_sat", 32'(bus.saturou), 1);
        reset_n     = 1'b0;
        bus.carrega = 1'b1;
        bus.dado    = 10'd7;
        #1;
        check("mrst_pre_q",  32'(bus.Q), 123);
        check("mrst_tick",   32'(bus.tick), 0);
        step();
        check("mrst_q",      32'(bus.Q), 0);
        check("mrst_lim",    32'(bus.lim), 499);
        check("mrst_sat",    32'(bus.saturou), 0);
        check("mrst_fim",    32'(bus.fim), 0);
        check("mrst_inicio", 32'(bus.inicio), 1);
        reset_n     = 1'b1;
        bus.carrega = 1'b0;
        bus.conta   = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
